// File: rtl/cpu_mem_pkg.sv
// Shared constants and address decode for the cpu memory/IO stage.
// Imported by the top and the transmit FIFO.
package cpu_mem_pkg;

    localparam logic [63:0] OFS_TXDATA   = 64'd0;
    localparam logic [63:0] OFS_CYCLE    = 64'd1;
    localparam logic [63:0] OFS_CLRFLAGS = 64'd2;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_STATUS,
        REG_CYCLE,
        REG_CLR,
        REG_NONE
    } region_t;

    function automatic region_t decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          ram_aw
    );
        if (addr < (64'd1 << ram_aw))
            return REG_RAM;
        else if (addr == base + OFS_TXDATA)
            return REG_STATUS;
        else if (addr == base + OFS_CYCLE)
            return REG_CYCLE;
        else if (addr == base + OFS_CLRFLAGS)
            return REG_CLR;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Circular transmit FIFO with one extra pointer bit for full/empty.
// Head word is shown combinationally; push on full is taken only with a pop.
module tx_fifo
    import cpu_mem_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [63:0]        push_data,
    input  logic               pop,
    output logic [63:0]        head,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [63:0]      mem [DEPTH];
    logic [FIFO_AW:0] wp;
    logic [FIFO_AW:0] rp;
    logic             do_pop;
    logic             do_push;

    assign empty = (wp == rp);
    assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                   (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    assign count = wp - rp;
    assign head  = mem[rp[FIFO_AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
        end
    end

    // Storage is deliberately not reset; the pointers define what is live.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wp[FIFO_AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cpu_mem_system.sv
// Memory/IO stage: word RAM, memory-mapped TX FIFO and a cycle counter.
// Reads are combinational; writes commit on the rising edge.
module cpu_mem_system
    import cpu_mem_pkg::*;
#(
    parameter int          RAM_AW  = 10,
    parameter int          FIFO_AW = 3,
    parameter logic [63:0] IO_BASE = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic [63:0] datao,
    input  logic        rw,
    output logic [63:0] data,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic [63:0]      ram [2 ** RAM_AW];
    logic [63:0]      cycle_cnt;
    logic             wr_prev;
    logic             overflow;
    region_t          region;
    logic             is_write;
    logic             io_write;
    logic             push;
    logic             pop;
    logic [FIFO_AW:0] count;
    logic             full;
    logic             empty;
    logic [63:0]      status;

    assign region   = decode(address, IO_BASE, RAM_AW);
    assign is_write = (rw == RW_WRITE);
    assign io_write = is_write && (region == REG_STATUS);

    // Only the first edge of a held write pushes.
    assign push = io_write && !wr_prev;
    assign pop  = tx_ready && !empty;

    assign tx_valid = !empty;

    tx_fifo #(
        .FIFO_AW(FIFO_AW)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(datao),
        .pop      (pop),
        .head     (tx_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock) begin
        if (is_write && region == REG_RAM)
            ram[address[RAM_AW-1:0]] <= datao;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            wr_prev   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            wr_prev   <= io_write;
            // A dropped push wins over a same-edge clear.
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (is_write && region == REG_CLR)
                overflow <= 1'b0;
        end
    end

    always_comb begin
        status              = '0;
        status[FIFO_AW:0]   = count;
        status[ST_EMPTY]    = empty;
        status[ST_FULL]     = full;
        status[ST_OVF]      = overflow;
    end

    always_comb begin
        data = '0;
        if (rw == RW_READ) begin
            unique case (region)
                REG_RAM:    data = ram[address[RAM_AW-1:0]];
                REG_STATUS: data = status;
                REG_CYCLE:  data = cycle_cnt;
                default:    data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_system.sv
// Directed plus randomized bench for cpu_mem_system against a queue model.
module tb_cpu_mem_system;
    import cpu_mem_pkg::*;

    localparam logic [63:0] IOB  = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] BEEF = 64'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] address;
    logic [63:0] datao;
    logic        rw;
    logic [63:0] data;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clock = ~clock;

    cpu_mem_system dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .datao   (datao),
        .rw      (rw),
        .data    (data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    bit          m_ovf;
    bit          m_prev;
    logic [63:0] m_cyc;
    logic [63:0] mram[logic [63:0]];
    logic [63:0] obs;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [63:0] m_status();
        logic [63:0] s;
        s = 64'(q.size());
        if (q.size() == 0) s = s + 64'h10000;
        if (q.size() == 8) s = s + 64'h20000;
        if (m_ovf)         s = s + 64'h40000;
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_prev = 0;
        m_cyc  = 0;
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit r, input logic [63:0] a,
                         input logic [63:0] d, input bit rdy);
        bit          known;
        bit          was_full;
        bit          popped;
        bit          setov;
        logic [63:0] e;
        rw       = r;
        address  = a;
        datao    = d;
        tx_ready = rdy;
        #1;
        obs   = data;
        known = 1;
        e     = 0;
        if (r) begin
            if (a < 64'd1024) begin
                known = mram.exists(a);
                if (known) e = mram[a];
            end else if (a == IOB) e = m_status();
            else if (a == IOB + 1) e = m_cyc;
        end
        if (known) chk("data", data, e);
        chk("tx_valid", 64'(tx_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", tx_data, q[0]);
        @(posedge clock);
        was_full = (q.size() == 8);
        popped   = rdy && (q.size() != 0);
        setov    = 0;
        if (popped) void'(q.pop_front());
        if (!r && a == IOB && !m_prev) begin
            if (!was_full || popped) q.push_back(d);
            else setov = 1;
        end
        if (setov) m_ovf = 1;
        else if (!r && a == IOB + 2) m_ovf = 0;
        if (!r && a < 64'd1024) mram[a] = d;
        m_prev = !r && (a == IOB);
        m_cyc  = m_cyc + 64'd1;
        @(negedge clock);
    endtask

    task automatic push_n(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            cycle(0, IOB, base + 64'(i), 0);
            cycle(1, IOB, 0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] v1;
        logic [63:0] last;
        rw       = 1;
        address  = IOB;
        datao    = 0;
        tx_ready = 0;
        model_reset();
        #2;
        chk("rst_status", data, 64'h10000);
        chk("rst_valid", 64'(tx_valid), 64'd0);
        @(negedge clock);
        reset = 1;

        cycle(1, IOB + 1, 0, 0);
        chk("cyc_start", obs, 64'd0);

        cycle(0, 5, BEEF, 0);
        cycle(1, 5, 0, 0);
        chk("ram5", obs, BEEF);
        cycle(1, 64'd1024, 0, 0);
        chk("ram_oob", obs, 64'd0);

        repeat (3) cycle(0, IOB, 64'h41, 0);
        cycle(1, IOB, 0, 0);
        chk("burst_status", obs, 64'd1);
        chk("burst_valid", 64'(tx_valid), 64'd1);
        chk("burst_head", tx_data, 64'h41);
        cycle(1, IOB, 0, 1);

        push_n(9, 64'd1);
        chk("ovf_status", obs, 64'h60008);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", tx_data, 64'(i));
            cycle(1, IOB, 0, 1);
        end
        chk("drained_valid", 64'(tx_valid), 64'd0);
        cycle(0, IOB + 2, {$urandom, $urandom}, 0);
        cycle(1, IOB, 0, 0);
        chk("clr_status", obs, 64'h10000);

        push_n(8, 64'h100);
        cycle(0, IOB, 64'hAA, 1);
        cycle(1, IOB, 0, 0);
        chk("full_pop_push", obs, 64'h20008);
        last = 0;
        while (tx_valid) begin
            last = tx_data;
            cycle(1, IOB, 0, 1);
        end
        chk("aa_last", last, 64'hAA);

        cycle(1, IOB + 1, 0, 0);
        v1 = obs;
        cycle(1, IOB + 1, 0, 0);
        chk("cyc_step", obs, v1 + 64'd1);
        force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        m_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(1, IOB + 1, 0, 0);
        chk("cyc_ones", obs, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1, IOB + 1, 0, 0);
        chk("cyc_wrap", obs, 64'd0);

        push_n(4, 64'h200);
        cycle(1, IOB, 0, 1);
        tx_ready = 1;
        address  = IOB;
        #1;
        reset = 0;
        model_reset();
        #1;
        chk("arst_valid", 64'(tx_valid), 64'd0);
        chk("arst_status", data, 64'h10000);
        address = IOB + 1;
        #1;
        chk("arst_cycle", data, 64'd0);
        address = 5;
        #1;
        chk("arst_ram5", data, BEEF);
        @(negedge clock);
        reset = 1;

        repeat (400) begin
            bit          rdy;
            logic [63:0] rd;
            rdy = ($urandom_range(0, 3) == 0);
            rd  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: cycle(0, 64'($urandom_range(0, 15)), rd, rdy);
                1: cycle(1, 64'($urandom_range(0, 15)), 0, rdy);
                2, 3: cycle(0, IOB, rd, rdy);
                4: cycle(1, IOB, 0, rdy);
                5: cycle(0, IOB + 2, rd, rdy);
                6: cycle(1, IOB + 1, 0, rdy);
                default: begin
                    case ($urandom_range(0, 2))
                        0: cycle($urandom_range(0, 1) == 1, 64'd1024, rd, rdy);
                        1: cycle($urandom_range(0, 1) == 1, IOB + 3, rd, rdy);
                        default: cycle($urandom_range(0, 1) == 1, IOB - 1, rd, rdy);
                    endcase
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_system.md
Name: cpu_mem_system

Overview:
- Memory/IO stage directly downstream of the cpu core.
- Consumes the core's address, datao and rw outputs; produces the data word the core reads.
- Contains word-addressed RAM, a memory-mapped transmit FIFO drained over a valid/ready port, and a free-running cycle counter.
- Is the only thing the core sees as memory.

Parameters:
- RAM_AW, 10: RAM holds 2**RAM_AW 64-bit words at word addresses 0 .. 2**RAM_AW-1.
- FIFO_AW, 3: TX FIFO depth is 2**FIFO_AW entries (8).
- IO_BASE, 64'hFFFF_FFFF_FFFF_FF00: base word address of the IO window.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low; reset=0 clears all state immediately.
- address, input, 64: word address from the core.
- datao, input, 64: write data from the core.
- rw, input, 1: 1=read, 0=write.
- data, output, 64: read data to the core.
- tx_data, output, 64: FIFO head word.
- tx_valid, output, 1: FIFO non-empty.
- tx_ready, input, 1: consumer accepts the head word this cycle.

Behaviour:
Interface (already decided): one clock, `clock`; reset is asynchronous and active-low, port `reset`.

Address decode:
- RAM: address < 2**RAM_AW.
- STATUS/TXDATA: IO_BASE+0.
- CYCLE: IO_BASE+1.
- CLRFLAGS: IO_BASE+2.
- Any other address is unmapped.

Reads (rw=1):
- `data` is combinational from `address`, valid in the same cycle, so the core samples it on its falling-edge capture.
- RAM: the stored word.
- STATUS: bits[FIFO_AW:0] = count; bit 16 = empty; bit 17 = full; bit 18 = overflow sticky; all other bits 0.
- CYCLE: counter value.
- CLRFLAGS and unmapped: 0.
- While rw=0, `data` = 0.

Writes (rw=0), committed on the rising edge:
- RAM: word written on every edge where rw=0. Repeats are idempotent.
- TXDATA: push datao only on the first edge of a write burst.
  - A registered wr_prev flag records "rw=0 and address==IO_BASE on the previous edge".
  - A push occurs when the IO write is present and wr_prev=0.
  - A core that holds rw low for 2+ cycles therefore pushes exactly once.
- CLRFLAGS: clears overflow on that edge, regardless of datao.
- Unmapped writes are dropped silently.

FIFO:
- Circular buffer; read and write pointers are FIFO_AW+1 bits wide, and full/empty come from the MSB compare.
- tx_data = head entry; tx_valid = !empty.
- Pop on edge when tx_valid && tx_ready.
- Push on full:
  - With a simultaneous pop: accepted, count stays 2**FIFO_AW.
  - Without a pop: word dropped, overflow set to 1.
- Push on empty with tx_ready=1: the word enters the FIFO. It is not bypassed, so first tx_valid is 1 cycle after the push edge.
- If CLRFLAGS and an overflowing push happen on the same edge, overflow ends at 1 (set wins).
- tx_data while empty is don't-care; the bench must not check it.

Cycle counter:
- 64-bit, +1 every rising edge, wraps from all-ones to 0.
- Counts 0 at the first edge after reset release.

Reset (reset=0):
- FIFO pointers 0, tx_valid=0, overflow=0, wr_prev=0, counter=0.
- RAM contents are not reset (undefined until written).
- data follows decode using the reset state: STATUS reads 64'h10000.
- Reset mid-burst or mid-drain discards FIFO contents. No push occurs on the release edge unless wr_prev=0 and a write is present.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - IO offset constants: OFS_TXDATA=0, OFS_CYCLE=1, OFS_CLRFLAGS=2.
  - STATUS bit positions: ST_EMPTY=16, ST_FULL=17, ST_OVF=18.
  - The rw encoding constants RW_READ=1, RW_WRITE=0.
- One sub-module, tx_fifo: parameter FIFO_AW; ports clock, reset, push, push_data, pop, head, count, full, empty.
- The top contains decode, RAM, counter, wr_prev and the overflow flag.

Test Plan:
1. Reset, then write RAM[5]=64'hDEAD_BEEF for one cycle; read address 5 → data=64'hDEAD_BEEF. Read address 2**RAM_AW → data=0.
2. Hold rw=0 at IO_BASE with datao=64'h41 for 3 cycles, tx_ready=0 → STATUS count=1, tx_valid=1, tx_data=64'h41.
3. Nine separate single-cycle pushes 1..9, tx_ready=0:
   - STATUS = full, count=8, overflow=1.
   - Draining with tx_ready=1 yields 1..8 in order, then tx_valid=0.
   - A write to CLRFLAGS clears overflow; STATUS=64'h10000.
4. FIFO full plus push 64'hAA with tx_ready=1 on the same edge → count stays 8, overflow stays 0, 64'hAA is the last word out.
5. Read CYCLE on two consecutive cycles → values differ by 1. Force the counter to all-ones → next value is 0.
6. Assert reset low mid-drain with 4 entries queued (asynchronous, between edges) → tx_valid=0 immediately, STATUS=64'h10000, counter=0. RAM[5] still reads 64'hDEAD_BEEF.
